// File: rtl/interconnect_pkg.sv
// Shared types and helpers for the AXI interconnect blocks.
package interconnect_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    AW   = 2'b01,
    DATA = 2'b10
  } wr_arb_state_e;

  // Width of a manager index; a single manager still needs one bit so the
  // ID prefix never collapses to zero width.
  function automatic int midx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester strictly after ptr,
// wrapping around, and returns both a one-hot grant and its index.
// Shared by the AW and AR arbiters of the crossbar.
module rr_arbiter
  import interconnect_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = midx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan ptr+1 .. ptr+N (mod N) and keep the first requester found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (en) begin
      for (int i = 1; i <= N; i++) begin
        cand = IW'((int'(ptr) + i) % N);
        if (!found && req[cand]) begin
          found           = 1'b1;
          grant[cand]     = 1'b1;
          grant_idx       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Per-subordinate AXI4 write-path arbiter: round-robin AW grant, W locked
// to the granted manager until WLAST, manager index prefixed onto AWID,
// B routed back by that prefix, outstanding writes bounded by MAX_OUTST.
module axi_wr_arbiter
  import interconnect_pkg::*;
#(
  parameter  int N_M        = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 64,
  parameter  int ID_WIDTH   = 4,
  parameter  int MAX_OUTST  = 8,
  localparam int MIDX_W     = midx_w(N_M),
  localparam int SID_W      = ID_WIDTH + MIDX_W,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int CNT_W      = $clog2(MAX_OUTST + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_M-1:0]            m_awvalid_i,
  input  logic [N_M*ADDR_WIDTH-1:0] m_awaddr_i,
  input  logic [N_M*ID_WIDTH-1:0]   m_awid_i,
  input  logic [N_M*8-1:0]          m_awlen_i,
  output logic [N_M-1:0]            m_awready_o,
  input  logic [N_M-1:0]            m_wvalid_i,
  input  logic [N_M*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [N_M*STRB_W-1:0]     m_wstrb_i,
  input  logic [N_M-1:0]            m_wlast_i,
  output logic [N_M-1:0]            m_wready_o,
  output logic [N_M-1:0]            m_bvalid_o,
  output logic [ID_WIDTH-1:0]       m_bid_o,
  output logic [1:0]                m_bresp_o,
  input  logic [N_M-1:0]            m_bready_i,
  output logic                      s_awvalid_o,
  output logic [ADDR_WIDTH-1:0]     s_awaddr_o,
  output logic [SID_W-1:0]          s_awid_o,
  output logic [7:0]                s_awlen_o,
  input  logic                      s_awready_i,
  output logic                      s_wvalid_o,
  output logic [DATA_WIDTH-1:0]     s_wdata_o,
  output logic [STRB_W-1:0]         s_wstrb_o,
  output logic                      s_wlast_o,
  input  logic                      s_wready_i,
  input  logic                      s_bvalid_i,
  input  logic [SID_W-1:0]          s_bid_i,
  input  logic [1:0]                s_bresp_i,
  output logic                      s_bready_o,
  output logic [CNT_W-1:0]          outst_o,
  output logic                      berr_o
);

  localparam logic [CNT_W-1:0]  OUTST_MAX = CNT_W'(MAX_OUTST);
  localparam logic [MIDX_W-1:0] PTR_INIT  = MIDX_W'(N_M - 1);

  // Per-manager views of the packed input buses.
  logic [ADDR_WIDTH-1:0] aw_addr [N_M];
  logic [ID_WIDTH-1:0]   aw_id   [N_M];
  logic [7:0]            aw_len  [N_M];
  logic [DATA_WIDTH-1:0] w_data  [N_M];
  logic [STRB_W-1:0]     w_strb  [N_M];

  genvar k;
  generate
    for (k = 0; k < N_M; k++) begin : g_unpack
      assign aw_addr[k] = m_awaddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign aw_id[k]   = m_awid_i[k*ID_WIDTH +: ID_WIDTH];
      assign aw_len[k]  = m_awlen_i[k*8 +: 8];
      assign w_data[k]  = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      assign w_strb[k]  = m_wstrb_i[k*STRB_W +: STRB_W];
    end
  endgenerate

  wr_arb_state_e         state;
  wr_arb_state_e         next_state;
  logic [MIDX_W-1:0]     ptr;
  logic [MIDX_W-1:0]     gnt;
  logic [MIDX_W-1:0]     arb_idx;
  logic [N_M-1:0]        arb_grant;
  logic                  arb_en;
  logic                  arb_hit;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [7:0]            sel_len;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [ID_WIDTH-1:0]   awid_q;
  logic [7:0]            awlen_q;
  logic [CNT_W-1:0]      outst;
  logic                  aw_hs;
  logic                  w_last_hs;
  logic                  b_hs;
  logic [MIDX_W-1:0]     b_idx;
  logic                  b_idx_ok;

  // New grants are only offered from IDLE and only while there is room
  // for another outstanding write.
  assign arb_en  = (state == IDLE) && (outst < OUTST_MAX);
  assign arb_hit = |arb_grant;

  rr_arbiter #(
    .N  (N_M),
    .IW (MIDX_W)
  ) u_rr (
    .req       (m_awvalid_i),
    .ptr       (ptr),
    .en        (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // One-hot AND-OR mux of the winner's AW payload for capture at grant time.
  always_comb begin
    sel_addr = '0;
    sel_id   = '0;
    sel_len  = '0;
    for (int i = 0; i < N_M; i++) begin
      if (arb_grant[i]) begin
        sel_addr = sel_addr | aw_addr[i];
        sel_id   = sel_id   | aw_id[i];
        sel_len  = sel_len  | aw_len[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic: IDLE -> AW on grant, AW -> DATA on AW handshake,
  // DATA -> IDLE on the WLAST handshake (leaving one idle bubble).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arb_hit)   next_state = AW;
      AW:      if (aw_hs)     next_state = DATA;
      DATA:    if (w_last_hs) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // FSM output logic: AW comes from the captured payload so it cannot move
  // while waiting for awready; W and the readies are steered to the winner.
  always_comb begin
    s_awvalid_o = (state == AW);
    s_awaddr_o  = awaddr_q;
    s_awid_o    = {gnt, awid_q};
    s_awlen_o   = awlen_q;
    m_awready_o = '0;
    if (state == AW) begin
      m_awready_o[gnt] = s_awready_i;
    end
    aw_hs = (state == AW) && s_awready_i;

    s_wvalid_o = (state == DATA) && m_wvalid_i[gnt];
    s_wdata_o  = w_data[gnt];
    s_wstrb_o  = w_strb[gnt];
    s_wlast_o  = m_wlast_i[gnt];
    m_wready_o = '0;
    if (state == DATA) begin
      m_wready_o[gnt] = s_wready_i;
    end
    w_last_hs = s_wvalid_o && s_wready_i && s_wlast_o;
  end

  // Grant bookkeeping: latch winner and its AW payload on grant, advance
  // the round-robin pointer once the AW has actually been accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr      <= PTR_INIT;
      gnt      <= '0;
      awaddr_q <= '0;
      awid_q   <= '0;
      awlen_q  <= '0;
    end else begin
      if ((state == IDLE) && arb_hit) begin
        gnt      <= arb_idx;
        awaddr_q <= sel_addr;
        awid_q   <= sel_id;
        awlen_q  <= sel_len;
      end
      if (aw_hs) begin
        ptr <= gnt;
      end
    end
  end

  // B routing by ID prefix; an out-of-range prefix is swallowed here and
  // flagged, since no manager could ever accept it.
  assign b_idx    = s_bid_i[ID_WIDTH +: MIDX_W];
  assign b_idx_ok = (int'(b_idx) < N_M);

  always_comb begin
    m_bvalid_o = '0;
    s_bready_o = 1'b0;
    berr_o     = 1'b0;
    m_bid_o    = s_bid_i[ID_WIDTH-1:0];
    m_bresp_o  = s_bresp_i;
    if (!rst_i) begin
      if (b_idx_ok) begin
        m_bvalid_o[b_idx] = s_bvalid_i;
        s_bready_o        = m_bready_i[b_idx];
      end else begin
        s_bready_o = 1'b1;
        berr_o     = s_bvalid_i;
      end
    end
    b_hs = s_bvalid_i && s_bready_o;
  end

  // Outstanding-write counter: up on AW, down on B, saturating at zero so a
  // stray B cannot wrap it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst <= '0;
    end else if (aw_hs && !b_hs) begin
      outst <= outst + CNT_W'(1);
    end else if (b_hs && !aw_hs && (outst != '0)) begin
      outst <= outst - CNT_W'(1);
    end
  end

  assign outst_o = outst;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with three managers and two
// outstanding writes, so both the out-of-range B prefix and the full
// counter can be exercised on one instance.
module tb_axi_wr_arbiter;

  localparam int NM   = 3;
  localparam int AWD  = 32;
  localparam int DW   = 32;
  localparam int IDW  = 4;
  localparam int MO   = 2;
  localparam int SW   = DW / 8;
  localparam int SIDW = IDW + 2;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
  logic [NM-1:0]     m_bvalid, m_bready;
  logic [NM*AWD-1:0] m_awaddr;
  logic [NM*IDW-1:0] m_awid;
  logic [NM*8-1:0]   m_awlen;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM*SW-1:0]  m_wstrb;
  logic [IDW-1:0]    m_bid;
  logic [1:0]        m_bresp;
  logic              s_awvalid, s_awready;
  logic [AWD-1:0]    s_awaddr;
  logic [SIDW-1:0]   s_awid;
  logic [7:0]        s_awlen;
  logic              s_wvalid, s_wready, s_wlast;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic              s_bvalid, s_bready;
  logic [SIDW-1:0]   s_bid;
  logic [1:0]        s_bresp;
  logic [CW-1:0]     outst;
  logic              berr;

  int vec_count = 0;
  int err_count = 0;
  int exp_g [4] = '{0, 1, 2, 0};
  int g;

  always #5 clk = ~clk;

  axi_wr_arbiter #(
    .N_M        (NM),
    .ADDR_WIDTH (AWD),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IDW),
    .MAX_OUTST  (MO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m_awvalid_i (m_awvalid),
    .m_awaddr_i  (m_awaddr),
    .m_awid_i    (m_awid),
    .m_awlen_i   (m_awlen),
    .m_awready_o (m_awready),
    .m_wvalid_i  (m_wvalid),
    .m_wdata_i   (m_wdata),
    .m_wstrb_i   (m_wstrb),
    .m_wlast_i   (m_wlast),
    .m_wready_o  (m_wready),
    .m_bvalid_o  (m_bvalid),
    .m_bid_o     (m_bid),
    .m_bresp_o   (m_bresp),
    .m_bready_i  (m_bready),
    .s_awvalid_o (s_awvalid),
    .s_awaddr_o  (s_awaddr),
    .s_awid_o    (s_awid),
    .s_awlen_o   (s_awlen),
    .s_awready_i (s_awready),
    .s_wvalid_o  (s_wvalid),
    .s_wdata_o   (s_wdata),
    .s_wstrb_o   (s_wstrb),
    .s_wlast_o   (s_wlast),
    .s_wready_i  (s_wready),
    .s_bvalid_i  (s_bvalid),
    .s_bid_i     (s_bid),
    .s_bresp_i   (s_bresp),
    .s_bready_o  (s_bready),
    .outst_o     (outst),
    .berr_o      (berr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearInputs();
    m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0;
    m_wvalid  = '0; m_wdata  = '0; m_wstrb = '0; m_wlast = '0;
    m_bready  = '0;
    s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid  = 1'b0; s_bid = '0; s_bresp = 2'b00;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // ---- 1: reset state, single 4-beat burst from manager 0, B back ----
    doReset();
    #1;
    checkOutput("rst_s_awvalid", s_awvalid, 0);
    checkOutput("rst_s_wvalid", s_wvalid, 0);
    checkOutput("rst_m_awready", m_awready, 0);
    checkOutput("rst_m_wready", m_wready, 0);
    checkOutput("rst_outst", outst, 0);
    checkOutput("rst_berr", berr, 0);
    checkOutput("rst_m_bvalid", m_bvalid, 0);
    checkOutput("rst_s_bready", s_bready, 0);
    m_awvalid = 3'b001; m_awaddr[0 +: AWD] = 32'h0000_1000;
    m_awid[0 +: IDW] = 4'd3; m_awlen[0 +: 8] = 8'd3;
    #1 checkOutput("t1_idle_awvalid", s_awvalid, 0);
    @(negedge clk); #1;
    checkOutput("t1_awvalid", s_awvalid, 1);
    checkOutput("t1_awid", s_awid, 6'b00_0011);
    checkOutput("t1_awaddr", s_awaddr, 32'h0000_1000);
    checkOutput("t1_awlen", s_awlen, 3);
    checkOutput("t1_awready_wait", m_awready, 0);
    s_awready = 1'b1;
    #1 checkOutput("t1_awready", m_awready, 3'b001);
    @(negedge clk);
    m_awvalid = '0; s_awready = 1'b0; s_wready = 1'b1; m_wvalid = 3'b001;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      m_wdata[0 +: DW] = 32'hA000_0000 + b; m_wstrb[0 +: SW] = 4'hF;
      m_wlast[0] = (b == 3);
      #1;
      checkOutput("t1_wvalid", s_wvalid, 1);
      checkOutput("t1_wdata", s_wdata, 32'hA000_0000 + b);
      checkOutput("t1_wlast", s_wlast, (b == 3));
      checkOutput("t1_wready", m_wready, 3'b001);
      checkOutput("t1_outst", outst, 1);
    end
    @(negedge clk);
    m_wvalid = '0; m_wlast = '0;
    #1 checkOutput("t1_bubble_wvalid", s_wvalid, 0);
    s_bvalid = 1'b1; s_bid = 6'b00_0011; m_bready = 3'b001;
    #1;
    checkOutput("t1_bvalid", m_bvalid, 3'b001);
    checkOutput("t1_bid", m_bid, 3);
    checkOutput("t1_bready", s_bready, 1);
    @(negedge clk);
    s_bvalid = 1'b0; m_bready = '0;
    #1 checkOutput("t1_outst_after_b", outst, 0);

    // ---- 2: all managers request, len 0 -> grants 0,1,2,0 every 3 cycles ----
    doReset();
    for (int i = 0; i < NM; i++) begin
      m_awaddr[i*AWD +: AWD] = 32'h100 * i;
      m_awid[i*IDW +: IDW]   = IDW'(i + 5);
      m_wdata[i*DW +: DW]    = 32'hD0 + i;
    end
    m_awvalid = 3'b111; m_wvalid = 3'b111; m_wlast = 3'b111;
    s_awready = 1'b1; s_wready = 1'b1;
    s_bvalid = 1'b1; s_bid = '0; m_bready = 3'b111;
    g = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      if (c % 3 == 1) begin
        g = exp_g[(c - 1) / 3];
        checkOutput("t2_awvalid", s_awvalid, 1);
        checkOutput("t2_awid", s_awid, (g << 4) | (g + 5));
        checkOutput("t2_awready", m_awready, 64'd1 << g);
      end else if (c % 3 == 2) begin
        checkOutput("t2_wvalid", s_wvalid, 1);
        checkOutput("t2_wready", m_wready, 64'd1 << g);
        checkOutput("t2_wdata", s_wdata, 32'hD0 + g);
      end else begin
        checkOutput("t2_bubble_awvalid", s_awvalid, 0);
        checkOutput("t2_bubble_wvalid", s_wvalid, 0);
      end
    end
    checkOutput("t2_outst", outst, 0);

    // ---- 3: MAX_OUTST=2, no B -> third AW held until one B returns ----
    doReset();
    for (int i = 0; i < NM; i++) m_awid[i*IDW +: IDW] = IDW'(i + 5);
    m_awvalid = 3'b111; m_wvalid = 3'b111; m_wlast = 3'b111;
    s_awready = 1'b1; s_wready = 1'b1; m_bready = 3'b111;
    repeat (6) @(negedge clk);
    #1 checkOutput("t3_outst_full", outst, 2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checkOutput("t3_held_awvalid", s_awvalid, 0);
      checkOutput("t3_held_outst", outst, 2);
    end
    s_bvalid = 1'b1; s_bid = {2'b01, 4'd6};
    #1;
    checkOutput("t3_bvalid", m_bvalid, 3'b010);
    checkOutput("t3_bid", m_bid, 6);
    @(negedge clk);
    s_bvalid = 1'b0;
    #1;
    checkOutput("t3_outst_dec", outst, 1);
    checkOutput("t3_still_idle", s_awvalid, 0);
    @(negedge clk); #1;
    checkOutput("t3_third_awvalid", s_awvalid, 1);
    checkOutput("t3_third_awid", s_awid, {2'd2, 4'd7});
    @(negedge clk); #1;
    checkOutput("t3_outst_refill", outst, 2);

    // ---- 4: W locked to manager 1, manager 2 held off, stall keeps W stable ----
    doReset();
    m_awvalid = 3'b010; m_awid[1*IDW +: IDW] = 4'h9; m_awlen[8 +: 8] = 8'd1;
    s_awready = 1'b1;
    @(negedge clk);
    m_awvalid = '0;
    #1;
    checkOutput("t4_awvalid_after_drop", s_awvalid, 1);
    checkOutput("t4_awid", s_awid, {2'b01, 4'h9});
    checkOutput("t4_awready", m_awready, 3'b010);
    @(negedge clk);
    s_awready = 1'b0; s_wready = 1'b0; m_wvalid = 3'b110;
    m_wdata[1*DW +: DW] = 32'h1111_1111; m_wdata[2*DW +: DW] = 32'h2222_2222;
    m_wstrb[1*SW +: SW] = 4'h3; m_wlast = 3'b100;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checkOutput("t4_stall_wvalid", s_wvalid, 1);
      checkOutput("t4_stall_wdata", s_wdata, 32'h1111_1111);
      checkOutput("t4_stall_wstrb", s_wstrb, 4'h3);
      checkOutput("t4_stall_wlast", s_wlast, 0);
      checkOutput("t4_stall_wready", m_wready, 3'b000);
    end
    @(negedge clk);
    s_wready = 1'b1;
    #1 checkOutput("t4_beat1_wready", m_wready, 3'b010);
    @(negedge clk);
    m_wdata[1*DW +: DW] = 32'h3333_3333; m_wlast = 3'b110;
    #1;
    checkOutput("t4_beat2_wdata", s_wdata, 32'h3333_3333);
    checkOutput("t4_beat2_wlast", s_wlast, 1);
    checkOutput("t4_beat2_wready", m_wready, 3'b010);
    @(negedge clk); #1;
    checkOutput("t4_idle_wvalid", s_wvalid, 0);
    checkOutput("t4_idle_wready", m_wready, 3'b000);
    checkOutput("t4_outst", outst, 1);

    // ---- 5: B prefix 2'b11 with three managers is dropped and flagged ----
    m_wvalid = '0; m_wlast = '0;
    s_bvalid = 1'b1; s_bid = 6'b11_0101; m_bready = '0;
    #1;
    checkOutput("t5_bready", s_bready, 1);
    checkOutput("t5_berr", berr, 1);
    checkOutput("t5_no_bvalid", m_bvalid, 0);
    checkOutput("t5_bid", m_bid, 5);
    @(negedge clk);
    s_bvalid = 1'b0;
    #1;
    checkOutput("t5_berr_pulse_end", berr, 0);
    checkOutput("t5_outst_dec", outst, 0);
    s_bvalid = 1'b1; s_bid = 6'b00_0010; m_bready = 3'b001;
    #1;
    checkOutput("t5_uf_bvalid", m_bvalid, 3'b001);
    checkOutput("t5_uf_bready", s_bready, 1);
    @(negedge clk);
    s_bvalid = 1'b0; m_bready = '0;
    #1 checkOutput("t5_no_underflow", outst, 0);

    // ---- 6: reset on beat 2 of 4 abandons the burst; manager 0 wins next ----
    doReset();
    m_awvalid = 3'b010; m_awid[1*IDW +: IDW] = 4'h7; m_awlen[8 +: 8] = 8'd3;
    s_awready = 1'b1;
    @(negedge clk); #1;
    checkOutput("t6_awvalid", s_awvalid, 1);
    @(negedge clk);
    m_awvalid = '0; s_awready = 1'b0; s_wready = 1'b1; m_wvalid = 3'b010;
    m_wdata[1*DW +: DW] = 32'hB000_0001; m_wlast = '0;
    #1;
    checkOutput("t6_beat1_wvalid", s_wvalid, 1);
    checkOutput("t6_beat1_outst", outst, 1);
    @(negedge clk);
    m_wdata[1*DW +: DW] = 32'hB000_0002;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_wvalid = '0;
    #1;
    checkOutput("t6_rst_awvalid", s_awvalid, 0);
    checkOutput("t6_rst_wvalid", s_wvalid, 0);
    checkOutput("t6_rst_outst", outst, 0);
    checkOutput("t6_rst_awready", m_awready, 0);
    checkOutput("t6_rst_wready", m_wready, 0);
    checkOutput("t6_rst_berr", berr, 0);
    m_awvalid = 3'b011; m_awid[0 +: IDW] = 4'h1;
    @(negedge clk); #1;
    checkOutput("t6_next_awvalid", s_awvalid, 1);
    checkOutput("t6_next_awid", s_awid, {2'b00, 4'h1});

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
